// File: rtl/alu_share_pkg.sv
// Shared types and defaults for the ALU sharing controller.
package alu_share_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned OUT_W_DEF  = 8;

    // Only add and subtract are implemented; 2'b10 and 2'b11 are answered with an error flag.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Any opcode with the upper bit set is unsupported.
    function automatic logic op_is_err(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/device.sv
// Combinational ALU: zero-extended add, two's-complement wrapping subtract.
module device
    import alu_share_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [1:0]        opcode,
    output logic [OUT_W-1:0]  out
);

    // Operands are widened to the result width before the operation so sub wraps at OUT_W.
    always_comb begin
        out = '0;
        case (opcode)
            OP_ADD:  out = OUT_W'(in1) + OUT_W'(in2);
            OP_SUB:  out = OUT_W'(in1) - OUT_W'(in2);
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request strictly after ptr, wrapping around.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    // Walk the requesters starting one past the last winner; the first hit wins.
    always_comb begin
        int unsigned          idx;
        logic [NUM_REQ-1:0]   req_sh;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        req_sh      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx    = (32'(ptr) + k) % NUM_REQ;
            req_sh = req >> idx;
            if (!grant_valid && req_sh[0]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
                grant_oh    = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU among NUM_REQ requesters: arbitrate, latch operands, execute, respond.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    parameter  int unsigned OUT_W   = OUT_W_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    input  logic [NUM_REQ*2-1:0]      req_opcode,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [OUT_W-1:0]          rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic                      busy
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   in1_q, in1_d;
    logic [DATA_W-1:0]   in2_q, in2_d;
    logic [1:0]          op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OUT_W-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;
    logic [OUT_W-1:0]    alu_out;

    logic [DATA_W-1:0]   in1_arr [NUM_REQ];
    logic [DATA_W-1:0]   in2_arr [NUM_REQ];
    logic [1:0]          op_arr  [NUM_REQ];

    // Unpack the flat request buses so the winner's fields can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign in1_arr[g] = req_in1[g*DATA_W +: DATA_W];
        assign in2_arr[g] = req_in2[g*DATA_W +: DATA_W];
        assign op_arr[g]  = req_opcode[g*2 +: 2];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The only ALU path; fed exclusively from the latched operands.
    device #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_alu (
        .in1    (in1_q),
        .in2    (in2_q),
        .opcode (op_q),
        .out    (alu_out)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        op_d       = op_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready = grant_oh;
                    in1_d     = in1_arr[grant_idx];
                    in2_d     = in2_arr[grant_idx];
                    op_d      = op_arr[grant_idx];
                    id_d      = grant_idx;
                    ptr_d     = grant_idx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_err_d  = op_is_err(op_q);
                rsp_data_d = op_is_err(op_q) ? '0 : alu_out;
                rsp_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight op and re-arms requester 0 as first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            in1_q      <= '0;
            in2_q      <= '0;
            op_q       <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            op_q       <= op_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_err  = rsp_err_q;

endmodule
